hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 30 +++
 rtl/hazard_scoreboard_div_sequencer.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants, hazard-cause encoding and EX-occupant record.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned NUM_REGS        = 32;
  localparam int unsigned DIV_LATENCY_DEF = 34;
  localparam int unsigned DIV_CNT_W       = 6;

  // Why ID is stalled this cycle; highest-priority cause wins.
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_RAW_RS1  = 3'd1,
    HZ_RAW_RS2  = 3'd2,
    HZ_WAW      = 3'd3,
    HZ_DIV_BUSY = 3'd4
  } hazard_cause_e;

  // Long-latency instruction that entered EX on the last edge.
  typedef struct packed {
    logic                  valid;
    logic                  is_div;
    logic [REG_ADDR_W-1:0] rd;
  } ex_occ_t;

  // One-hot register select.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    reg_onehot = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_div_sequencer.sv
// Sequencer for the single shared iterative divider: countdown, busy and done pulse.
module div_sequencer
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_issue_i,
  input  logic flush_i,
  output logic div_busy_o,
  output logic div_done_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LATENCY - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  // Next-state: a new issue (including back-to-back in the done cycle) reloads;
  // a flushed divide aborts silently; otherwise count down and retire at zero.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (div_issue_i) begin
      cnt_d  = CNT_LOAD;
      busy_d = 1'b1;
    end else if (flush_i) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - DIV_CNT_W'(1);
      end
    end
  end

  // Counter and busy state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign div_busy_o = busy_q;
  assign div_done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Outstanding long-latency writer scoreboard with ID stall decode and divider sequencing.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_div,
  input  logic                  ex_flush,
  input  logic                  wb_long_valid,
  input  logic [REG_ADDR_W-1:0] wb_long_rd,
  output logic                  stall_id,
  output logic                  issue,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [NUM_REGS-1:0]   pending_mask
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_vec, flush_vec, set_vec, pend_live;
  ex_occ_t             occ_q, occ_d;
  hazard_cause_e       hazard_cause_c;
  logic                long_issue, div_issue, flush_occ, flush_div;

  // Writeback clears bypass into the hazard check since the register file writes through.
  always_comb begin
    clr_vec   = wb_long_valid ? reg_onehot(wb_long_rd) : '0;
    pend_live = pending_q & ~clr_vec;
  end

  // Stall cause decode, in priority order.
  always_comb begin
    hazard_cause_c = HZ_NONE;
    if (id_valid) begin
      if (id_rs1_used && (id_rs1_addr != '0) && pend_live[id_rs1_addr]) begin
        hazard_cause_c = HZ_RAW_RS1;
      end else if (id_rs2_used && (id_rs2_addr != '0) && pend_live[id_rs2_addr]) begin
        hazard_cause_c = HZ_RAW_RS2;
      end else if (id_reg_write && (id_rd != '0) && pend_live[id_rd]) begin
        hazard_cause_c = HZ_WAW;
      end else if (id_is_div && div_busy && !div_done) begin
        hazard_cause_c = HZ_DIV_BUSY;
      end
    end
  end

  assign stall_id   = (hazard_cause_c != HZ_NONE);
  assign issue      = id_valid && !stall_id;
  assign long_issue = issue && id_reg_write && (id_is_load || id_is_div);
  assign div_issue  = long_issue && id_is_div;
  assign flush_occ  = ex_flush && occ_q.valid;
  assign flush_div  = flush_occ && occ_q.is_div;

  // Bitmap next-state: clears first, then new issue sets so set wins on collision.
  always_comb begin
    flush_vec    = flush_occ ? reg_onehot(occ_q.rd) : '0;
    set_vec      = (long_issue && (id_rd != '0)) ? reg_onehot(id_rd) : '0;
    pending_d    = (pending_q & ~clr_vec & ~flush_vec) | set_vec;
    occ_d        = '0;
    occ_d.valid  = long_issue;
    occ_d.is_div = id_is_div;
    occ_d.rd     = id_rd;
  end

  // Scoreboard and EX-occupant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      occ_q     <= '0;
    end else begin
      pending_q <= pending_d;
      occ_q     <= occ_d;
    end
  end

  assign pending_mask = pending_q;

  div_sequencer #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_div_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_issue_i (div_issue),
    .flush_i     (flush_div),
    .div_busy_o  (div_busy),
    .div_done_o  (div_done)
  );

  // A long writeback must target a register that is actually outstanding.
  a_wb_pending : assert property (@(posedge clk) disable iff (!rst_n)
    wb_long_valid |-> pending_q[wb_long_rd])
    else $error("long writeback to non-pending register x%0d", wb_long_rd);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  localparam int unsigned L = 34;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic       id_rs1_used;
  logic [4:0] id_rs2_addr;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       id_is_div;
  logic       ex_flush;
  logic       wb_long_valid;
  logic [4:0] wb_long_rd;
  logic       stall_id;
  logic       issue;
  logic       div_busy;
  logic       div_done;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;
  int done_seen;

  hazard_scoreboard #(.DIV_LATENCY(L)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs2_used   (id_rs2_used),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_is_load    (id_is_load),
    .id_is_div     (id_is_div),
    .ex_flush      (ex_flush),
    .wb_long_valid (wb_long_valid),
    .wb_long_rd    (wb_long_rd),
    .stall_id      (stall_id),
    .issue         (issue),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .pending_mask  (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic dv);
    id_valid     = v;
    id_rs1_addr  = rs1;
    id_rs1_used  = u1;
    id_rs2_addr  = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    id_is_div    = dv;
    #1;
  endtask

  task automatic clr_id();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd);
    wb_long_valid = v;
    wb_long_rd    = rd;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ex_flush = 1'b0;
    set_wb(1'b0, 5'd0);
    clr_id();
    tick();
    tick();
    chk("rst_pending", pending_mask, 32'h0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_done", 32'(div_done), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // lw x5 then add x6,x5,x1 stalls until writeback of x5
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("lw5_issue", 32'(issue), 32'd1);
    tick();
    chk("lw5_pending", pending_mask, 32'h20);
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("raw5_stall", 32'(stall_id), 32'd1);
    chk("raw5_noissue", 32'(issue), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("raw5_hold", 32'(stall_id), 32'd1);
    end
    set_wb(1'b1, 5'd5);
    chk("raw5_wb_bypass", 32'(stall_id), 32'd0);
    chk("raw5_wb_issue", 32'(issue), 32'd1);
    tick();
    set_wb(1'b0, 5'd0);
    clr_id();
    chk("raw5_cleared", pending_mask, 32'h0);

    // div x7 then div x8 back-to-back
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    chk("div7_issue", 32'(issue), 32'd1);
    tick();
    chk("div7_busy", 32'(div_busy), 32'd1);
    chk("div7_pending", pending_mask, 32'h80);
    set_id(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < int'(L); k++) begin
      chk("div8_stall", 32'(stall_id), 32'd1);
      chk("div7_early_done", 32'(div_done), 32'd0);
      tick();
    end
    chk("div7_done", 32'(div_done), 32'd1);
    chk("div8_b2b_stall", 32'(stall_id), 32'd0);
    chk("div8_b2b_issue", 32'(issue), 32'd1);
    tick();
    clr_id();
    chk("div8_busy", 32'(div_busy), 32'd1);
    chk("div8_done_low", 32'(div_done), 32'd0);
    chk("div78_pending", pending_mask, 32'h180);
    set_wb(1'b1, 5'd7);
    tick();
    set_wb(1'b0, 5'd0);
    chk("div7_wb", pending_mask, 32'h100);
    for (int k = 2; k <= int'(L); k++) begin
      chk("div8_done_timing", 32'(div_done), (k == int'(L)) ? 32'd1 : 32'd0);
      tick();
    end
    chk("div8_idle", 32'(div_busy), 32'd0);
    set_wb(1'b1, 5'd8);
    tick();
    set_wb(1'b0, 5'd0);
    chk("div8_wb", pending_mask, 32'h0);

    // x0 destination and sources are never tracked
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("lw0_stall", 32'(stall_id), 32'd0);
    tick();
    chk("lw0_pending", pending_mask, 32'h0);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("x0_read_stall", 32'(stall_id), 32'd0);
    tick();
    clr_id();
    chk("x0_read_pending", pending_mask, 32'h0);

    // div x9 flushed out of EX: silent abort
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("div9_issue", 32'(issue), 32'd1);
    tick();
    clr_id();
    chk("div9_pending", pending_mask, 32'h200);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    chk("div9_flush_pending", pending_mask, 32'h0);
    chk("div9_flush_busy", 32'(div_busy), 32'd0);
    done_seen = 0;
    for (int k = 0; k < int'(L) + 2; k++) begin
      if (div_done) done_seen++;
      tick();
    end
    chk("div9_no_done", 32'(done_seen), 32'd0);

    // writeback of x5 and new lw x5 in the same cycle: set wins
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lw5b_pending", pending_mask, 32'h20);
    set_wb(1'b1, 5'd5);
    chk("lw5c_issue", 32'(issue), 32'd1);
    tick();
    set_wb(1'b0, 5'd0);
    chk("set_wins", pending_mask, 32'h20);
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("raw5b_stall", 32'(stall_id), 32'd1);
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("waw5_stall", 32'(stall_id), 32'd1);
    clr_id();
    set_wb(1'b1, 5'd5);
    tick();
    set_wb(1'b0, 5'd0);
    chk("lw5c_wb", pending_mask, 32'h0);

    // reset with three pending and a divide running
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    chk("div11_issue", 32'(issue), 32'd1);
    tick();
    clr_id();
    chk("pre_rst_pending", pending_mask, 32'h818);
    chk("pre_rst_busy", 32'(div_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_pending", pending_mask, 32'h0);
    chk("mid_rst_busy", 32'(div_busy), 32'd0);
    chk("mid_rst_done", 32'(div_done), 32'd0);
    done_seen = 0;
    for (int k = 0; k < int'(L) + 2; k++) begin
      if (div_done) done_seen++;
      tick();
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
